// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
// Bundles the instruction handshake and result/strobe bus of the A/B
// accumulator execute unit.
//   master : instruction source (drives iValid, iOpcode, iAddress, iA, iB)
//   slave  : execute unit (drives oReady, oValid, oData, write/read strobes,
//            RAM write enable, RAM address and the two carry flags)
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  iValid;
  logic                  oReady;
  logic [5:0]            iOpcode;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] iA;
  logic [DATA_WIDTH-1:0] iB;
  logic                  oValid;
  logic [DATA_WIDTH-1:0] oData;
  logic                  oWriteA;
  logic                  oWriteB;
  logic                  oReadA;
  logic                  oReadB;
  logic                  oRamEnableWrite;
  logic [ADDR_WIDTH-1:0] oRamAddress;
  logic                  oCa;
  logic                  oCb;

  modport master (
    output iValid, iOpcode, iAddress, iA, iB,
    input  oReady, oValid, oData, oWriteA, oWriteB, oReadA, oReadB,
           oRamEnableWrite, oRamAddress, oCa, oCb
  );

  modport slave (
    input  iValid, iOpcode, iAddress, iA, iB,
    output oReady, oValid, oData, oWriteA, oWriteB, oReadA, oReadB,
           oRamEnableWrite, oRamAddress, oCa, oCb
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Registered execute unit for the A/B accumulator processor. Accepts one
// decoded instruction per cycle (iValid && oReady), computes from the current
// A/B values and presents registered write-back, RAM-access and carry flags.
// Multiplies take DATA_WIDTH cycles using a shift-add datapath.
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : alu_exec_unit_if slave modport (handshake, operands, results)
module alu_exec_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input logic           Clock,
  input logic           Reset,
  alu_exec_unit_if.slave bus
);
  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [5:0] OP_ADDA  = 6'd1,  OP_ADDB  = 6'd2,  OP_ADDCA = 6'd3;
  localparam logic [5:0] OP_ADDCB = 6'd4,  OP_SUBA  = 6'd5,  OP_SUBB  = 6'd6;
  localparam logic [5:0] OP_SUBCA = 6'd7,  OP_SUBCB = 6'd8,  OP_ANDA  = 6'd9;
  localparam logic [5:0] OP_ANDB  = 6'd10, OP_ORA   = 6'd11, OP_ORB   = 6'd12;
  localparam logic [5:0] OP_ASLA  = 6'd13, OP_ASRA  = 6'd14, OP_ASLB  = 6'd15;
  localparam logic [5:0] OP_ASRB  = 6'd16, OP_LDA   = 6'd17, OP_LDB   = 6'd18;
  localparam logic [5:0] OP_STA   = 6'd19, OP_STB   = 6'd20, OP_LDCA  = 6'd21;
  localparam logic [5:0] OP_LDCB  = 6'd22, OP_MULA  = 6'd23, OP_MULB  = 6'd24;

  typedef enum logic {IDLE, MUL} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      count;
  logic [PROD_W-1:0]     mul_mcand, mul_acc, mul_acc_next;
  logic [DATA_WIDTH-1:0] mul_mplier;
  logic                  mul_to_b;

  logic                  valid_q, write_a_q, write_b_q, read_a_q, read_b_q, ram_we_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ca_q, cb_q;

  logic                  accept, is_mul_op, mul_done;

  // Decoded single-cycle result
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] res_data;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic                  res_flag, upd_ca, upd_cb;
  logic                  res_wa, res_wb, res_ra, res_rb, res_we;

  assign bus.oReady  = (state == IDLE) && !Reset;
  assign accept      = bus.iValid && bus.oReady;
  assign is_mul_op   = (bus.iOpcode == OP_MULA) || (bus.iOpcode == OP_MULB);
  assign mul_done    = (state == MUL) && (count == CNT_W'(DATA_WIDTH - 1));
  // One partial product per cycle: add the shifted multiplicand when the
  // current multiplier LSB is set.
  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  assign bus.oValid          = valid_q;
  assign bus.oData           = data_q;
  assign bus.oWriteA         = write_a_q;
  assign bus.oWriteB         = write_b_q;
  assign bus.oReadA          = read_a_q;
  assign bus.oReadB          = read_b_q;
  assign bus.oRamEnableWrite = ram_we_q;
  assign bus.oRamAddress     = addr_q;
  assign bus.oCa             = ca_q;
  assign bus.oCb             = cb_q;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul_op) state_next = MUL;
      MUL:  if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arithmetic runs at DATA_WIDTH+1 bits so the top bit is carry on add and
  // borrow on subtract (a negative result leaves bit DATA_WIDTH set).
  always_comb begin
    wide     = '0;
    res_data = data_q;
    res_addr = addr_q;
    res_flag = 1'b0;
    upd_ca   = 1'b0;
    upd_cb   = 1'b0;
    res_wa   = 1'b0;
    res_wb   = 1'b0;
    res_ra   = 1'b0;
    res_rb   = 1'b0;
    res_we   = 1'b0;
    case (bus.iOpcode)
      OP_ADDA, OP_ADDB: wide = {1'b0, bus.iA} + {1'b0, bus.iB};
      OP_ADDCA: wide = {1'b0, bus.iA} + {1'b0, bus.iB} + {{DATA_WIDTH{1'b0}}, ca_q};
      OP_ADDCB: wide = {1'b0, bus.iB} + {1'b0, bus.iA} + {{DATA_WIDTH{1'b0}}, cb_q};
      OP_SUBA:  wide = {1'b0, bus.iA} - {1'b0, bus.iB};
      OP_SUBB:  wide = {1'b0, bus.iB} - {1'b0, bus.iA};
      OP_SUBCA: wide = {1'b0, bus.iA} - {1'b0, bus.iB} - {{DATA_WIDTH{1'b0}}, ca_q};
      OP_SUBCB: wide = {1'b0, bus.iB} - {1'b0, bus.iA} - {{DATA_WIDTH{1'b0}}, cb_q};
      default:  wide = '0;
    endcase
    case (bus.iOpcode)
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA: begin
        res_data = wide[DATA_WIDTH-1:0];
        res_flag = wide[DATA_WIDTH];
        upd_ca   = 1'b1;
        res_wa   = 1'b1;
      end
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB: begin
        res_data = wide[DATA_WIDTH-1:0];
        res_flag = wide[DATA_WIDTH];
        upd_cb   = 1'b1;
        res_wb   = 1'b1;
      end
      OP_ANDA: begin res_data = bus.iA & bus.iB; res_wa = 1'b1; end
      OP_ANDB: begin res_data = bus.iA & bus.iB; res_wb = 1'b1; end
      OP_ORA:  begin res_data = bus.iA | bus.iB; res_wa = 1'b1; end
      OP_ORB:  begin res_data = bus.iA | bus.iB; res_wb = 1'b1; end
      OP_ASLA: begin
        res_data = {bus.iA[DATA_WIDTH-2:0], 1'b0};
        res_flag = bus.iA[DATA_WIDTH-1];
        upd_ca   = 1'b1;
        res_wa   = 1'b1;
      end
      OP_ASRA: begin
        res_data = {bus.iA[DATA_WIDTH-1], bus.iA[DATA_WIDTH-1:1]};
        res_flag = bus.iA[0];
        upd_ca   = 1'b1;
        res_wa   = 1'b1;
      end
      OP_ASLB: begin
        res_data = {bus.iB[DATA_WIDTH-2:0], 1'b0};
        res_flag = bus.iB[DATA_WIDTH-1];
        upd_cb   = 1'b1;
        res_wb   = 1'b1;
      end
      OP_ASRB: begin
        res_data = {bus.iB[DATA_WIDTH-1], bus.iB[DATA_WIDTH-1:1]};
        res_flag = bus.iB[0];
        upd_cb   = 1'b1;
        res_wb   = 1'b1;
      end
      OP_LDA:  begin res_addr = bus.iAddress; res_ra = 1'b1; end
      OP_LDB:  begin res_addr = bus.iAddress; res_rb = 1'b1; end
      OP_STA:  begin res_addr = bus.iAddress; res_data = bus.iA; res_we = 1'b1; end
      OP_STB:  begin res_addr = bus.iAddress; res_data = bus.iB; res_we = 1'b1; end
      OP_LDCA: begin res_data = bus.iAddress[DATA_WIDTH-1:0]; res_wa = 1'b1; end
      OP_LDCB: begin res_data = bus.iAddress[DATA_WIDTH-1:0]; res_wb = 1'b1; end
      default: ;
    endcase
  end

  // Output registers and multiply datapath. Strobes and oValid are pulses:
  // cleared every cycle unless a result is produced. A multiply latches its
  // operands at acceptance so later iA/iB changes do not disturb it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      write_a_q  <= 1'b0;
      write_b_q  <= 1'b0;
      read_a_q   <= 1'b0;
      read_b_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      ca_q       <= 1'b0;
      cb_q       <= 1'b0;
      count      <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_to_b   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      write_a_q <= 1'b0;
      write_b_q <= 1'b0;
      read_a_q  <= 1'b0;
      read_b_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      if (accept) begin
        if (is_mul_op) begin
          mul_mcand  <= {{DATA_WIDTH{1'b0}}, bus.iA};
          mul_mplier <= bus.iB;
          mul_acc    <= '0;
          count      <= '0;
          mul_to_b   <= (bus.iOpcode == OP_MULB);
        end else begin
          valid_q   <= 1'b1;
          data_q    <= res_data;
          addr_q    <= res_addr;
          write_a_q <= res_wa;
          write_b_q <= res_wb;
          read_a_q  <= res_ra;
          read_b_q  <= res_rb;
          ram_we_q  <= res_we;
          if (upd_ca) ca_q <= res_flag;
          if (upd_cb) cb_q <= res_flag;
        end
      end else if (state == MUL) begin
        mul_acc    <= mul_acc_next;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        count      <= count + CNT_W'(1);
        if (mul_done) begin
          count   <= '0;
          valid_q <= 1'b1;
          data_q  <= mul_acc_next[DATA_WIDTH-1:0];
          if (mul_to_b) begin
            write_b_q <= 1'b1;
            cb_q      <= |mul_acc_next[PROD_W-1:DATA_WIDTH];
          end else begin
            write_a_q <= 1'b1;
            ca_q      <= |mul_acc_next[PROD_W-1:DATA_WIDTH];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: a table of single-cycle vectors
// issued back-to-back, followed by hand-written multiply and reset sequences.
module tb_alu_exec_unit;
  localparam int DW = 8;
  localparam int AW = 10;

  localparam logic [4:0] S_WA = 5'b10000, S_WB = 5'b01000, S_RA = 5'b00100;
  localparam logic [4:0] S_RB = 5'b00010, S_WE = 5'b00001, S_NO = 5'b00000;

  typedef struct {
    logic [5:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] data;
    logic [4:0]    strb;
    logic [AW-1:0] ram;
    logic          ca;
    logic          cb;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  alu_exec_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  alu_exec_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  // Compare one observed value with its hand-computed expectation.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one instruction onto the issue side of the bus.
  task automatic apply_stimulus(input logic valid, input logic [5:0] op,
                                input logic [AW-1:0] addr, input logic [DW-1:0] a,
                                input logic [DW-1:0] b);
    bus.iValid   = valid;
    bus.iOpcode  = op;
    bus.iAddress = addr;
    bus.iA       = a;
    bus.iB       = b;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.oWriteA, bus.oWriteB, bus.oReadA, bus.oReadB, bus.oRamEnableWrite};
  endfunction

  // Issue a multiply, hold a different instruction on the bus while busy,
  // then check latency, result, flags and that the held instruction follows.
  task automatic run_mul(input string name, input logic [5:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                         input logic [4:0] exp_strb, input logic exp_ca, input logic exp_cb);
    int  cycles;
    bit  found;
    bit  early;
    apply_stimulus(1'b1, op, '0, a, b);
    tick();
    check_output({name, " busy ready"}, bus.oReady, 1'b0);
    check_output({name, " busy valid"}, bus.oValid, 1'b0);
    apply_stimulus(1'b1, 6'd2, '0, 8'h03, 8'h04);
    found  = 1'b0;
    early  = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick();
      if (bus.oValid) begin
        found  = 1'b1;
        cycles = k;
      end else if (bus.oReady) begin
        early = 1'b1;
      end
    end
    check_output({name, " latency"}, cycles, DW);
    check_output({name, " early ready"}, early, 1'b0);
    check_output({name, " data"}, bus.oData, exp_data);
    check_output({name, " strobes"}, strobes(), exp_strb);
    check_output({name, " flags"}, {bus.oCa, bus.oCb}, {exp_ca, exp_cb});
    check_output({name, " ready after"}, bus.oReady, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, '0);
    check_output({name, " held ADDB data"}, bus.oData, 8'h07);
    check_output({name, " held ADDB strobes"}, strobes(), S_WB);
    check_output({name, " held ADDB flags"}, {bus.oCa, bus.oCb}, {exp_ca, 1'b0});
  endtask

  initial begin
    int seen_valid;

    // op, addr, a, b -> data, strobes, ram addr, ca, cb
    vq.push_back(vec_t'{6'd1,  10'h000, 8'hF0, 8'h20, 8'h10, S_WA, 10'h000, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd3,  10'h000, 8'h01, 8'h01, 8'h03, S_WA, 10'h000, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd5,  10'h000, 8'h05, 8'h07, 8'hFE, S_WA, 10'h000, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd9,  10'h000, 8'hFE, 8'h0F, 8'h0E, S_WA, 10'h000, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd20, 10'h3A5, 8'h00, 8'h5C, 8'h5C, S_WE, 10'h3A5, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd17, 10'h001, 8'h00, 8'h00, 8'h5C, S_RA, 10'h001, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd14, 10'h000, 8'h81, 8'h00, 8'hC0, S_WA, 10'h001, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd15, 10'h000, 8'h00, 8'h81, 8'h02, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd63, 10'h000, 8'h00, 8'h00, 8'h02, S_NO, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd6,  10'h000, 8'h03, 8'h01, 8'hFE, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd8,  10'h000, 8'h00, 8'h05, 8'h04, S_WB, 10'h001, 1'b1, 1'b0});
    vq.push_back(vec_t'{6'd2,  10'h000, 8'h80, 8'h80, 8'h00, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd4,  10'h000, 8'h00, 8'hFF, 8'h00, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd7,  10'h000, 8'h00, 8'h00, 8'hFF, S_WA, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd11, 10'h000, 8'h50, 8'h05, 8'h55, S_WA, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd12, 10'h000, 8'h0F, 8'hF0, 8'hFF, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd10, 10'h000, 8'h3C, 8'h0F, 8'h0C, S_WB, 10'h001, 1'b1, 1'b1});
    vq.push_back(vec_t'{6'd13, 10'h000, 8'h40, 8'h00, 8'h80, S_WA, 10'h001, 1'b0, 1'b1});
    vq.push_back(vec_t'{6'd16, 10'h000, 8'h00, 8'h7E, 8'h3F, S_WB, 10'h001, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd21, 10'h2AB, 8'h00, 8'h00, 8'hAB, S_WA, 10'h001, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd22, 10'h155, 8'h00, 8'h00, 8'h55, S_WB, 10'h001, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd18, 10'h200, 8'h00, 8'h00, 8'h55, S_RB, 10'h200, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd19, 10'h0FF, 8'h77, 8'h00, 8'h77, S_WE, 10'h0FF, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd0,  10'h000, 8'h00, 8'h00, 8'h77, S_NO, 10'h0FF, 1'b0, 1'b0});
    vq.push_back(vec_t'{6'd25, 10'h000, 8'h00, 8'h00, 8'h77, S_NO, 10'h0FF, 1'b0, 1'b0});

    $display("[TB] reset");
    apply_stimulus(1'b0, '0, '0, '0, '0);
    Reset = 1'b1;
    tick();
    tick();
    check_output("reset ready low", bus.oReady, 1'b0);
    check_output("reset valid", bus.oValid, 1'b0);
    check_output("reset data", bus.oData, '0);
    check_output("reset strobes", strobes(), S_NO);
    check_output("reset ram addr", bus.oRamAddress, '0);
    check_output("reset flags", {bus.oCa, bus.oCb}, 2'b00);
    Reset = 1'b0;
    #1;
    check_output("ready after reset", bus.oReady, 1'b1);

    $display("[TB] back-to-back vector table");
    for (int i = 0; i < vq.size(); i++) begin
      apply_stimulus(1'b1, vq[i].op, vq[i].addr, vq[i].a, vq[i].b);
      tick();
      check_output($sformatf("v%0d valid", i), bus.oValid, 1'b1);
      check_output($sformatf("v%0d data", i), bus.oData, vq[i].data);
      check_output($sformatf("v%0d strobes", i), strobes(), vq[i].strb);
      check_output($sformatf("v%0d ram addr", i), bus.oRamAddress, vq[i].ram);
      check_output($sformatf("v%0d flags", i), {bus.oCa, bus.oCb}, {vq[i].ca, vq[i].cb});
    end
    apply_stimulus(1'b0, '0, '0, '0, '0);
    tick();
    check_output("idle valid low", bus.oValid, 1'b0);
    check_output("idle strobes low", strobes(), S_NO);

    $display("[TB] multiply sequences");
    run_mul("MULA 0F*11", 6'd23, 8'h0F, 8'h11, 8'hFF, S_WA, 1'b0, 1'b0);
    run_mul("MULB 10*10", 6'd24, 8'h10, 8'h10, 8'h00, S_WB, 1'b0, 1'b1);
    run_mul("MULA FF*FF", 6'd23, 8'hFF, 8'hFF, 8'h01, S_WA, 1'b1, 1'b0);

    $display("[TB] reset during multiply");
    apply_stimulus(1'b1, 6'd23, '0, 8'h0F, 8'h11);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) tick();
    Reset = 1'b1;
    tick();
    check_output("abort ready low", bus.oReady, 1'b0);
    check_output("abort valid", bus.oValid, 1'b0);
    check_output("abort data", bus.oData, '0);
    check_output("abort strobes", strobes(), S_NO);
    check_output("abort ram addr", bus.oRamAddress, '0);
    check_output("abort flags", {bus.oCa, bus.oCb}, 2'b00);
    Reset = 1'b0;
    #1;
    check_output("abort ready after", bus.oReady, 1'b1);
    seen_valid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.oValid) seen_valid++;
    end
    check_output("abort no late valid", seen_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
